// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational imem.
// The fetch stage drives the address and samples the read data in the same cycle.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, IF/ID pipeline register and
// saturating stall/flush event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                should_stall_data_hazard,
    input  logic                should_stall_control_hazard,
    input  logic [1:0]          should_j_or_branch_or_jr,
    input  logic [31:0]         jr_target,
    fetch_stage_if.master       imem,
    output logic [31:0]         pc,
    output logic [31:0]         id_instruction,
    output logic [31:0]         id_pc_plus_4,
    output logic                id_is_NOP,
    output logic [15:0]         stall_count,
    output logic [15:0]         flush_count
);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_BRANCH = 2'b10,
        SEL_JR     = 2'b11
    } sel_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_plus_4_q, pc_plus_4_d;
    logic               is_nop_q, is_nop_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic [15:0]        flush_cnt_q, flush_cnt_d;

    logic [31:0]        seq_pc;
    logic [31:0]        jump_target;
    logic signed [31:0] branch_offset;
    logic [31:0]        branch_target;
    logic [31:0]        redirect_target;
    sel_e               sel;

    assign sel = sel_e'(should_j_or_branch_or_jr);

    // Targets depend only on the instruction already sitting in IF/ID, never on imem.
    always_comb begin
        seq_pc          = pc_q + 32'd4;
        jump_target     = {pc_plus_4_q[31:28], instr_q[25:0], 2'b00};
        branch_offset   = signed'({{14{instr_q[15]}}, instr_q[15:0], 2'b00});
        branch_target   = pc_plus_4_q + unsigned'(branch_offset);
        redirect_target = pc_q;
        unique case (sel)
            SEL_JUMP:   redirect_target = jump_target;
            SEL_BRANCH: redirect_target = branch_target;
            SEL_JR:     redirect_target = jr_target;
            default:    redirect_target = pc_q;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus_4_d = pc_plus_4_q;
        is_nop_d    = is_nop_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (should_stall_data_hazard) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (should_stall_control_hazard) begin
            // A flush with no target selected re-fetches the current PC behind a bubble.
            if (sel != SEL_SEQ) begin
                pc_d = redirect_target;
            end
            instr_d     = NOP_WORD;
            pc_plus_4_d = 32'd0;
            is_nop_d    = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            pc_d        = seq_pc;
            instr_d     = imem.imem_rdata;
            pc_plus_4_d = seq_pc;
            is_nop_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_WORD;
            pc_plus_4_q <= 32'd0;
            is_nop_q    <= 1'b1;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus_4_q <= pc_plus_4_d;
            is_nop_q    <= is_nop_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign id_instruction = instr_q;
    assign id_pc_plus_4   = pc_plus_4_q;
    assign id_is_NOP      = is_nop_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes expected IF state
// per edge into a scoreboard queue, popped and compared after each edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        nop;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ds;
    logic        ch;
    logic [1:0]  sel;
    logic [31:0] jt;
    logic [31:0] pc, id_instruction, id_pc_plus_4;
    logic        id_is_NOP;
    logic [15:0] stall_count, flush_count;

    logic        ovr_en;
    logic [31:0] ovr_word;

    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_nop;
    logic [15:0] m_sc, m_fc;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .should_stall_data_hazard    (ds),
        .should_stall_control_hazard (ch),
        .should_j_or_branch_or_jr    (sel),
        .jr_target                   (jt),
        .imem                        (bus),
        .pc                          (pc),
        .id_instruction              (id_instruction),
        .id_pc_plus_4                (id_pc_plus_4),
        .id_is_NOP                   (id_is_NOP),
        .stall_count                 (stall_count),
        .flush_count                 (flush_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction

    assign bus.imem_rdata = ovr_en ? ovr_word : mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic d, input logic c,
                        input logic [1:0] s, input logic [31:0] j, input bit do_chk);
        exp_t        e;
        string       t;
        logic [31:0] fetched;
        logic [31:0] tgt;
        rst = r; ds = d; ch = c; sel = s; jt = j;
        fetched = ovr_en ? ovr_word : mem_word(m_pc);
        case (s)
            2'b01:   tgt = {m_pp4[31:28], m_instr[25:0], 2'b00};
            2'b10:   tgt = m_pp4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
            2'b11:   tgt = j;
            default: tgt = m_pc;
        endcase
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_pp4 = 32'h0; m_nop = 1'b1; m_sc = 16'h0; m_fc = 16'h0;
        end else if (d) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        end else if (c) begin
            m_pc = tgt; m_instr = NOP; m_pp4 = 32'h0; m_nop = 1'b1;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end else begin
            m_instr = fetched; m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_nop = 1'b0;
        end
        e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.nop = m_nop; e.sc = m_sc; e.fc = m_fc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (do_chk) begin
            chk({t, ".pc"},        pc,                  e.pc);
            chk({t, ".imem_addr"}, bus.imem_addr,       e.pc);
            chk({t, ".instr"},     id_instruction,      e.instr);
            chk({t, ".pp4"},       id_pc_plus_4,        e.pp4);
            chk({t, ".nop"},       {31'd0, id_is_NOP},  {31'd0, e.nop});
            chk({t, ".stall"},     {16'd0, stall_count}, {16'd0, e.sc});
            chk({t, ".flush"},     {16'd0, flush_count}, {16'd0, e.fc});
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; ds = 1'b0; ch = 1'b0; sel = 2'b00; jt = 32'h0;
        ovr_en = 1'b0; ovr_word = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_nop = 1'b0; m_sc = 16'h0; m_fc = 16'h0;

        step("rst0", 1, 0, 0, 2'b00, 32'h0, 1);
        step("rst_over", 1, 1, 1, 2'b10, 32'h0, 1);
        chk("reset_pc_const", pc, 32'h0000_0000);
        chk("reset_nop_const", {31'd0, id_is_NOP}, 32'd1);

        // Sequential fetch to pc=8, then two data-stall cycles.
        step("seq1", 0, 0, 0, 2'b00, 32'h0, 1);
        step("seq2", 0, 0, 0, 2'b00, 32'h0, 1);
        chk("seq2_pp4_const", id_pc_plus_4, 32'h8);
        step("stall1", 0, 1, 0, 2'b00, 32'h0, 1);
        step("stall2", 0, 1, 1, 2'b01, 32'h0, 1);
        chk("stall_cnt_const", {16'd0, stall_count}, 32'd2);
        step("resume", 0, 0, 0, 2'b00, 32'h0, 1);
        chk("resume_pc_const", pc, 32'hC);
        for (int i = 0; i < 4; i++) step("seq", 0, 0, 0, 2'b00, 32'h0, 1);

        // Fetch a beq with imm -2 at 0x1C, then take it.
        ovr_en = 1'b1; ovr_word = 32'h1000_FFFE;
        step("fetch_beq", 0, 0, 0, 2'b00, 32'h0, 1);
        ovr_en = 1'b0;
        step("branch", 0, 0, 1, 2'b10, 32'h0, 1);
        chk("branch_pc_const", pc, 32'h18);
        step("after_branch", 0, 0, 0, 2'b00, 32'h0, 1);
        chk("after_branch_instr_const", id_instruction, 32'hC000_0018);

        // jr to 0x1000_0000, fetch a j with target field 0x40, take it, then jr to 0x44.
        step("jr_far", 0, 0, 1, 2'b11, 32'h1000_0000, 1);
        ovr_en = 1'b1; ovr_word = 32'h0800_0040;
        step("fetch_j", 0, 0, 0, 2'b00, 32'h0, 1);
        ovr_en = 1'b0;
        step("jump", 0, 0, 1, 2'b01, 32'h0, 1);
        chk("jump_pc_const", pc, 32'h1000_0100);
        step("jr44", 0, 0, 1, 2'b11, 32'h44, 1);
        chk("jr_pc_const", pc, 32'h44);
        step("after_jr", 0, 0, 0, 2'b00, 32'h0, 1);

        // Stall beats flush; then flush alone redirects.
        step("prio_both", 0, 1, 1, 2'b10, 32'h0, 1);
        step("prio_flush", 0, 0, 1, 2'b11, 32'h80, 1);
        step("after_prio", 0, 0, 0, 2'b00, 32'h0, 1);

        // Illegal flush with select 00, select without flush, fetched NOP word.
        step("flush_sel00", 0, 0, 1, 2'b00, 32'h0, 1);
        step("refetch", 0, 0, 0, 2'b00, 32'h0, 1);
        step("sel_no_flush", 0, 0, 0, 2'b01, 32'h999, 1);
        ovr_en = 1'b1; ovr_word = NOP;
        step("fetched_nop", 0, 0, 0, 2'b00, 32'h0, 1);
        ovr_en = 1'b0;

        // PC wrap at the top of the address space.
        step("jr_top", 0, 0, 1, 2'b11, 32'hFFFF_FFFC, 1);
        step("wrap", 0, 0, 0, 2'b00, 32'h0, 1);
        chk("wrap_pc_const", pc, 32'h0);
        step("post_wrap", 0, 0, 0, 2'b00, 32'h0, 1);

        // Reset during a redirecting flush, then first fetch from RESET_PC.
        step("rst_in_flush", 1, 0, 1, 2'b11, 32'h500, 1);
        step("first_fetch", 0, 0, 0, 2'b00, 32'h0, 1);
        chk("first_fetch_instr_const", id_instruction, 32'hC000_0000);

        // Stall counter saturation over 65537 stall cycles.
        for (int i = 1; i <= 65537; i++) begin
            step("stall_sat", 0, 1, 0, 2'b00, 32'h0, (i >= 65534));
        end
        chk("stall_sat_const", {16'd0, stall_count}, 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
